spi_char_writer: RTL
====================

Name: spi_char_writer

Overview:
- SPI mode-0 slave that receives character frames from the DSP and writes them into the LCD character RAM write port.
- Drives the RAM write signals addressDsp, dataDsp and wren, and raises the LCD controller's update request.
- Runs entirely in the system clock domain and oversamples SCLK, MOSI and CS_N.
- This is the writer on the DSP-facing side of the character RAM; the LCD controller is the reader on the other side.

Parameters:
- SYNC_STAGES, 2, number of synchronizer flops on spi_sclk, spi_mosi and spi_cs_n (minimum 2).
- ADDR_LIMIT, 32, number of character locations. Burst address wraps to 0 at this value.

Ports:
- clk  input  1  system clock; the only clock.
- sysrst  input  1  asynchronous, active-high reset.
- spi_sclk  input  1  SPI clock from DSP; must be at most clk/8.
- spi_mosi  input  1  SPI data in, MSB first.
- spi_cs_n  input  1  SPI chip select, active low.
- spi_miso  output  1  SPI data out; echoes the previous byte.
- addressDsp  output  8  character RAM write address; bit 7 is always 0.
- dataDsp  output  8  character RAM write data.
- wren  output  1  character RAM write enable; one-cycle pulse.
- update  output  1  LCD refresh request; one-cycle pulse.
- frame_err  output  1  sticky error flag.

Behaviour:
- Reset: all outputs are 0. All state, shift registers and counters are 0. FSM state is IDLE. Synchronizer flops reset to SCLK=0, CS_N=1, MOSI=0.
- Input synchronization:
  - Each input passes through SYNC_STAGES flops.
  - An SCLK rising or falling edge is detected by comparing the last two synchronized samples.
  - All decisions use synchronized values only.
- Bit reception:
  - On a synchronized SCLK rising edge with CS_N low, shift MOSI into rx_shift (MSB first) and increment a 3-bit bit counter.
  - When the counter wraps from 7 to 0, the byte is complete.
- spi_miso:
  - At each byte completion, tx_shift is loaded with the byte just received.
  - On each SCLK falling edge with CS_N low, tx_shift shifts left.
  - spi_miso is tx_shift[7]; it is 0 during the first byte of a frame and whenever CS_N is high.
- FSM states: IDLE, ADDR, DATA, CMD.
  - IDLE: on CS_N falling, clear the bit counter and go to ADDR.
  - ADDR, byte complete:
    - If byte[7]=0 and byte[6:0] < ADDR_LIMIT: addr_reg = byte; go to DATA.
    - If byte[7]=0 and byte[6:0] >= ADDR_LIMIT: set frame_err; go to CMD (remaining bytes are ignored).
    - If byte[7]=1 (command): byte 0x80 pulses update for one cycle; byte 0xC0 clears frame_err; any other command value sets frame_err. Then go to CMD.
  - DATA, byte complete:
    - Next cycle: dataDsp = byte, addressDsp = {1'b0, addr_reg[6:0]}, wren = 1 for exactly one clk cycle.
    - addr_reg increments; if the result equals ADDR_LIMIT it becomes 0.
    - Stay in DATA (burst mode).
  - CMD: ignore all further bytes until CS_N rises.
  - CS_N rising in any state: go to IDLE and clear the bit counter.
- Write timing:
  - Latency from the 8th SCLK rising edge (at the pin) to wren high is at most SYNC_STAGES+2 clk cycles.
  - addressDsp and dataDsp are valid in the wren cycle and hold until the next write.
- Boundary conditions:
  - CS_N rises mid-byte (bit counter not 0): discard the partial byte and set frame_err. No wren and no update.
  - CS_N rises in ADDR with no byte received: return to IDLE, no error.
  - Byte completion and CS_N rising in the same synchronized cycle: process the byte first (the write/command occurs), then go to IDLE.
  - Burst longer than ADDR_LIMIT: addresses wrap and overwrite from 0.
  - sysrst asserted mid-frame: everything returns to reset values immediately. The frame is lost. After reset, the FSM waits for a fresh CS_N falling edge and does not resume mid-frame, even if CS_N is still low.
- Counters and comparisons are unsigned; addr_reg is 7 bits.

Test Plan:
- Single write: CS low, send 0x05 then 0x41, CS high → exactly one wren pulse with addressDsp=0x05, dataDsp=0x41; update=0; frame_err=0.
- Burst with wrap: send address 0x1E then data 0x61, 0x62, 0x63 → three wren pulses at addresses 0x1E, 0x1F, 0x00 with data 0x61, 0x62, 0x63.
- Commands: frame 0x80 → one update pulse, no wren. Frame 0x85 → frame_err=1. Frame 0xC0 → frame_err=0.
- Aborted byte: send address 0x03, 4 bits of data, then CS high → no wren, frame_err=1. A following clean frame 0x03, 0x5A writes correctly.
- Out-of-range and echo: address 0x25 → frame_err=1 and subsequent data bytes produce no wren. In frame 0x02, 0x33, 0x44, spi_miso shifts out 0x00, 0x02, 0x33 during bytes 1–3.
- Reset mid-burst: assert sysrst during the 2nd data byte → all outputs 0 at once. Release sysrst with CS_N still low, clock more bytes → no wren until CS_N goes high and a new frame starts.

Source files
------------

// File: rtl/spi_char_writer.sv
// SPI mode-0 slave, oversampled in the clk domain, that writes character frames
// (address byte + burst of data bytes, or a single command byte) into the LCD character RAM.
//
// state | meaning
// IDLE  | waiting for a CS_N falling edge
// ADDR  | first byte of frame: address or command
// DATA  | burst data bytes, one RAM write per byte
// CMD   | frame consumed or rejected; ignore bytes until CS_N rises
module spi_char_writer #(
  parameter int SYNC_STAGES = 2,
  parameter int ADDR_LIMIT  = 32
) (
  input  logic       clk,
  input  logic       sysrst,
  input  logic       spi_sclk,
  input  logic       spi_mosi,
  input  logic       spi_cs_n,
  output logic       spi_miso,
  output logic [7:0] addressDsp,
  output logic [7:0] dataDsp,
  output logic       wren,
  output logic       update,
  output logic       frame_err
);

  typedef enum logic [1:0] {IDLE, ADDR, DATA, CMD} state_t;

  localparam logic [7:0] LIMIT8   = 8'(ADDR_LIMIT);
  localparam logic [7:0] FILL_CYC = 8'(SYNC_STAGES + 1);

  logic [SYNC_STAGES-1:0] sclk_sync_q, sclk_sync_d;
  logic [SYNC_STAGES-1:0] mosi_sync_q, mosi_sync_d;
  logic [SYNC_STAGES-1:0] cs_sync_q, cs_sync_d;
  logic       sclk_d1_q, sclk_d1_d;
  logic       cs_d1_q, cs_d1_d;
  logic [7:0] fill_cnt_q, fill_cnt_d;
  logic       armed_q, armed_d;
  state_t     state_q, state_d;
  logic [2:0] bit_cnt_q, bit_cnt_d;
  logic [6:0] rx_shift_q, rx_shift_d;
  logic [7:0] tx_shift_q, tx_shift_d;
  logic [6:0] addr_q, addr_d;
  logic [6:0] addr_out_q, addr_out_d;
  logic [7:0] data_out_q, data_out_d;
  logic       wren_q, wren_d;
  logic       update_q, update_d;
  logic       err_q, err_d;
  logic       miso_q, miso_d;

  logic       sclk_s, mosi_s, cs_s;
  logic       sclk_rise, sclk_fall, cs_fall, cs_rise, cs_low;
  logic [7:0] byte_val;
  logic       byte_done;
  logic [7:0] addr_inc;

  assign sclk_s    = sclk_sync_q[SYNC_STAGES-1];
  assign mosi_s    = mosi_sync_q[SYNC_STAGES-1];
  assign cs_s      = cs_sync_q[SYNC_STAGES-1];
  assign sclk_rise = sclk_s & ~sclk_d1_q;
  assign sclk_fall = ~sclk_s & sclk_d1_q;
  // A CS_N fall only opens a frame once CS_N has been seen high after reset,
  // so a frame interrupted by reset is never resumed.
  assign cs_fall   = cs_d1_q & ~cs_s & armed_q;
  assign cs_rise   = ~cs_d1_q & cs_s;
  assign cs_low    = ~cs_d1_q;
  assign byte_val  = {rx_shift_q, mosi_s};
  assign byte_done = sclk_rise & cs_low & (bit_cnt_q == 3'd7);
  assign addr_inc  = {1'b0, addr_q} + 8'd1;

  always_comb begin
    sclk_sync_d = {sclk_sync_q[SYNC_STAGES-2:0], spi_sclk};
    mosi_sync_d = {mosi_sync_q[SYNC_STAGES-2:0], spi_mosi};
    cs_sync_d   = {cs_sync_q[SYNC_STAGES-2:0], spi_cs_n};
    sclk_d1_d   = sclk_s;
    cs_d1_d     = cs_s;
    fill_cnt_d  = (fill_cnt_q != FILL_CYC) ? fill_cnt_q + 8'd1 : fill_cnt_q;
    armed_d     = armed_q | ((fill_cnt_q == FILL_CYC) & cs_s & cs_d1_q);
    state_d     = state_q;
    bit_cnt_d   = bit_cnt_q;
    rx_shift_d  = rx_shift_q;
    tx_shift_d  = tx_shift_q;
    addr_d      = addr_q;
    addr_out_d  = addr_out_q;
    data_out_d  = data_out_q;
    wren_d      = 1'b0;
    update_d    = 1'b0;
    err_d       = err_q;

    if (sclk_rise && cs_low) begin
      rx_shift_d = byte_val[6:0];
      bit_cnt_d  = bit_cnt_q + 3'd1;
    end

    // The falling edge right after a byte completes is skipped so the echoed
    // MSB is still on MISO for the master's first sample of the next byte.
    if (byte_done) begin
      tx_shift_d = byte_val;
    end else if (sclk_fall && cs_low && (bit_cnt_q != 3'd0)) begin
      tx_shift_d = {tx_shift_q[6:0], 1'b0};
    end

    case (state_q)
      IDLE: begin
        if (cs_fall) begin
          state_d    = ADDR;
          bit_cnt_d  = 3'd0;
          tx_shift_d = 8'h00;
        end
      end
      ADDR: begin
        if (byte_done) begin
          if (!byte_val[7]) begin
            if ({1'b0, byte_val[6:0]} < LIMIT8) begin
              addr_d  = byte_val[6:0];
              state_d = DATA;
            end else begin
              err_d   = 1'b1;
              state_d = CMD;
            end
          end else begin
            if (byte_val == 8'h80)      update_d = 1'b1;
            else if (byte_val == 8'hC0) err_d    = 1'b0;
            else                        err_d    = 1'b1;
            state_d = CMD;
          end
        end
      end
      DATA: begin
        if (byte_done) begin
          wren_d     = 1'b1;
          data_out_d = byte_val;
          addr_out_d = addr_q;
          addr_d     = (addr_inc == LIMIT8) ? 7'd0 : addr_inc[6:0];
        end
      end
      CMD: begin
      end
      default: state_d = IDLE;
    endcase

    if (cs_rise) begin
      if ((state_q != IDLE) && (bit_cnt_q != 3'd0) && !byte_done) err_d = 1'b1;
      state_d   = IDLE;
      bit_cnt_d = 3'd0;
    end

    miso_d = ~cs_s & tx_shift_d[7];
  end

  always_ff @(posedge clk or posedge sysrst) begin
    if (sysrst) begin
      sclk_sync_q <= '0;
      mosi_sync_q <= '0;
      cs_sync_q   <= '1;
      sclk_d1_q   <= 1'b0;
      cs_d1_q     <= 1'b1;
      fill_cnt_q  <= 8'd0;
      armed_q     <= 1'b0;
      state_q     <= IDLE;
      bit_cnt_q   <= 3'd0;
      rx_shift_q  <= 7'd0;
      tx_shift_q  <= 8'd0;
      addr_q      <= 7'd0;
      addr_out_q  <= 7'd0;
      data_out_q  <= 8'd0;
      wren_q      <= 1'b0;
      update_q    <= 1'b0;
      err_q       <= 1'b0;
      miso_q      <= 1'b0;
    end else begin
      sclk_sync_q <= sclk_sync_d;
      mosi_sync_q <= mosi_sync_d;
      cs_sync_q   <= cs_sync_d;
      sclk_d1_q   <= sclk_d1_d;
      cs_d1_q     <= cs_d1_d;
      fill_cnt_q  <= fill_cnt_d;
      armed_q     <= armed_d;
      state_q     <= state_d;
      bit_cnt_q   <= bit_cnt_d;
      rx_shift_q  <= rx_shift_d;
      tx_shift_q  <= tx_shift_d;
      addr_q      <= addr_d;
      addr_out_q  <= addr_out_d;
      data_out_q  <= data_out_d;
      wren_q      <= wren_d;
      update_q    <= update_d;
      err_q       <= err_d;
      miso_q      <= miso_d;
    end
  end

  assign spi_miso   = miso_q;
  assign addressDsp = {1'b0, addr_out_q};
  assign dataDsp    = data_out_q;
  assign wren       = wren_q;
  assign update     = update_q;
  assign frame_err  = err_q;

endmodule
